// File: rtl/vga_pkg.sv
// Shared VGA constants for the 640x480 timing generator and its consumers:
// frame geometry, test-pattern codes and the colour-bar table.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_BOX   = 2'd3
  } pat_e;

  // {R,G,B} on/off per bar, left to right.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Bar number for a horizontal position: 80-pixel bars, anything past
  // the last threshold lands in bar 7.
  function automatic logic [2:0] bar_index(input logic [9:0] h);
    if      (h < 10'd80)  return 3'd0;
    else if (h < 10'd160) return 3'd1;
    else if (h < 10'd240) return 3'd2;
    else if (h < 10'd320) return 3'd3;
    else if (h < 10'd400) return 3'd4;
    else if (h < 10'd480) return 3'd5;
    else if (h < 10'd560) return 3'd6;
    else                  return 3'd7;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for timing flags, with an asynchronous
// active-low reset that loads a per-bit reset value into every stage.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the flags one stage per clock; reset parks them at RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator for the 640x480 pixel pipeline.
// Two register stages: S1 captures timing and computes the pattern colour,
// S2 applies blanking. Every output lags its input sample by two clocks.
// The pattern is latched at frame start (0,0), so a frame shows one pattern.
// Optional macro PATTERN_SCROLL_EN: box moves 2 px per frame and the
// checker scrolls left by frame_cnt; without it both are static.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W     = 4,
  parameter int CHECK_SHIFT = 5,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_Y       = 208
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               de_in,
  input  logic [1:0]         pat_sel,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out,
  output logic               frame_tick
);

  localparam logic [COLOR_W-1:0] ONES = '1;
  localparam logic [COLOR_W-1:0] ZERO = '0;

  logic       fs;
  pat_e       pat_active;
  pat_e       pat_cur;
  logic [7:0] frame_cnt;

  assign fs = (hcount == 10'd0) && (vcount == 10'd0);
  // Pixel (0,0) already belongs to the new frame, so it uses the new request.
  assign pat_cur = fs ? pat_e'(pat_sel) : pat_active;

  // Latch the pattern and count frames at frame start.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      pat_active <= PAT_BARS;
      frame_cnt  <= 8'd0;
    end else if (fs) begin
      pat_active <= pat_e'(pat_sel);
      frame_cnt  <= frame_cnt + 8'd1;
    end
  end

  logic        chk_h;
  logic [10:0] box_x;
`ifdef PATTERN_SCROLL_EN
  logic [7:0] fc_cur;
  assign fc_cur = fs ? frame_cnt + 8'd1 : frame_cnt;
  assign chk_h  = |((11'(hcount) + 11'(fc_cur)) & (11'd1 << CHECK_SHIFT));
  assign box_x  = {2'b00, fc_cur, 1'b0};
`else
  assign chk_h  = hcount[CHECK_SHIFT];
  assign box_x  = 11'd288;
`endif

  // Box compare is done at 11 bits so box_x + BOX_SIZE cannot wrap.
  logic [10:0] h_ext;
  logic        in_box;
  assign h_ext  = {1'b0, hcount};
  assign in_box = (h_ext >= box_x) && (h_ext < box_x + 11'(BOX_SIZE)) &&
                  (vcount >= 10'(BOX_Y)) && ({1'b0, vcount} < 11'(BOX_Y + BOX_SIZE));

  logic [2:0]         bar_bits;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  assign bar_bits = BAR_RGB[bar_index(hcount)];

  // Colour of the current input pixel for the pattern in force.
  always_comb begin
    pix_r = ZERO;
    pix_g = ZERO;
    pix_b = ZERO;
    case (pat_cur)
      PAT_BARS: begin
        pix_r = bar_bits[2] ? ONES : ZERO;
        pix_g = bar_bits[1] ? ONES : ZERO;
        pix_b = bar_bits[0] ? ONES : ZERO;
      end
      PAT_CHECK: begin
        pix_r = (chk_h ^ vcount[CHECK_SHIFT]) ? ONES : ZERO;
        pix_g = pix_r;
        pix_b = pix_r;
      end
      PAT_GRAD: begin
        pix_r = COLOR_W'(hcount[9:6]);
        pix_g = COLOR_W'(vcount[8:5]);
      end
      PAT_BOX: begin
        pix_r = in_box ? ONES : ZERO;
        pix_g = in_box ? ONES : ZERO;
        pix_b = ONES;
      end
      default: ;
    endcase
  end

  logic [3*COLOR_W-1:0] rgb_s1;

  // S1: register the pattern colour.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) rgb_s1 <= '0;
    else         rgb_s1 <= {pix_r, pix_g, pix_b};
  end

  // Timing flags {hsync, vsync, de, fs}; syncs idle high.
  logic [3:0] sync_in, sync_s1, sync_s2;
  assign sync_in = {hsync_in, vsync_in, de_in, fs};

  vga_sync_delay #(.DEPTH(1), .WIDTH(4), .RST_VAL(4'b1100)) u_sync_s1 (
    .clk   (clk_pix),
    .rst_n (resetn),
    .d     (sync_in),
    .q     (sync_s1)
  );

  vga_sync_delay #(.DEPTH(1), .WIDTH(4), .RST_VAL(4'b1100)) u_sync_s2 (
    .clk   (clk_pix),
    .rst_n (resetn),
    .d     (sync_s1),
    .q     (sync_s2)
  );

  // S2: blank the colour outside active video.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn)         {red, green, blue} <= '0;
    else if (sync_s1[1]) {red, green, blue} <= rgb_s1;
    else                 {red, green, blue} <= '0;
  end

  assign hsync_out  = sync_s2[3];
  assign vsync_out  = sync_s2[2];
  assign de_out     = sync_s2[1];
  assign frame_tick = sync_s2[0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed pixels, a behavioural colour model,
// an expected queue checked every cycle, and a few literal model pins.
module tb_vga_pattern_gen;

  logic       clk_pix = 1'b0;
  logic       resetn;
  logic [9:0] hcount, vcount;
  logic       hsync_in, vsync_in, de_in;
  logic [1:0] pat_sel;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, de_out, frame_tick;

  localparam logic [15:0] RST_EXP = 16'h000C;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  int m_pat = 0;
  int m_fc  = 0;
  int fs_count = 0;
  int hs_low_total = 0;
  int tick_total = 0;
  logic [1:0] sel = 2'd0;

  // ---------------- clock ----------------
  always #5 clk_pix = ~clk_pix;

  vga_pattern_gen dut (
    .clk_pix(clk_pix), .resetn(resetn), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .pat_sel(pat_sel),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .de_out(de_out), .frame_tick(frame_tick)
  );

  // ---------------- model ----------------
  function automatic logic [11:0] model_rgb(int h, int v, int pat, int fc);
    int b, hh, bx;
    logic [11:0] c;
    c = 12'h000;
    case (pat)
      0: begin
        b = h / 80;
        if (b > 7) b = 7;
        case (b)
          0: c = 12'hFFF; 1: c = 12'hFF0; 2: c = 12'h0FF; 3: c = 12'h0F0;
          4: c = 12'hF0F; 5: c = 12'hF00; 6: c = 12'h00F; default: c = 12'h000;
        endcase
      end
      1: begin
`ifdef PATTERN_SCROLL_EN
        hh = h + fc;
`else
        hh = h;
`endif
        c = (((hh / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      end
      2: c = {4'((h / 64) % 16), 4'((v / 32) % 16), 4'h0};
      default: begin
`ifdef PATTERN_SCROLL_EN
        bx = 2 * fc;
`else
        bx = 288;
`endif
        c = (h >= bx && h < bx + 64 && v >= 208 && v < 272) ? 12'hFFF : 12'h00F;
      end
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk_pix) begin
    logic [15:0] got;
    got = {red, green, blue, hsync_out, vsync_out, de_out, frame_tick};
    if (!resetn) begin
      check("reset_out", got, RST_EXP);
    end else begin
      if (!hsync_out) hs_low_total++;
      if (frame_tick) tick_total++;
      if (exp_q.size() >= 3) check("pixel_out", got, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int h, input int v, input logic de, input logic hs,
                      input logic vs, input logic [1:0] ps);
    logic fs;
    logic [11:0] rgb;
    fs = (h == 0 && v == 0);
    hcount = 10'(h); vcount = 10'(v);
    de_in = de; hsync_in = hs; vsync_in = vs; pat_sel = ps;
    if (fs) begin
      m_pat = int'(ps);
      m_fc = (m_fc + 1) % 256;
      fs_count++;
    end
    rgb = de ? model_rgb(h, v, m_pat, m_fc) : 12'h000;
    exp_q.push_back({rgb, hs, vs, de, fs});
    @(posedge clk_pix); #1;
  endtask

  task automatic pix(input int h, input int v);
    step(h, v, (h < 640 && v < 480), !(h >= 656 && h < 752),
         !(v >= 490 && v < 492), sel);
  endtask

  task automatic idle(input int n);
    repeat (n) pix(799, 524);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    m_pat = 0;
    m_fc = 0;
    exp_q.delete();
    exp_q.push_back(RST_EXP);
    exp_q.push_back(RST_EXP);
    repeat (n) @(posedge clk_pix);
    #1;
    resetn = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int hs_before;
    resetn = 1'b0;
    hcount = 10'd799; vcount = 10'd524;
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; pat_sel = 2'd0;
    exp_q.push_back(RST_EXP);
    exp_q.push_back(RST_EXP);
    repeat (3) @(posedge clk_pix);
    #1;
    resetn = 1'b1;

    // Literal pins on the model.
    check("pin_bar0",   {4'h0, model_rgb(0,   10, 0, 0)}, 16'h0FFF);
    check("pin_bar80",  {4'h0, model_rgb(80,  10, 0, 0)}, 16'h0FF0);
    check("pin_bar240", {4'h0, model_rgb(240, 10, 0, 0)}, 16'h00F0);
    check("pin_bar600", {4'h0, model_rgb(600, 10, 0, 0)}, 16'h0000);
    check("pin_chk00",  {4'h0, model_rgb(0,   0,  1, 0)}, 16'h0000);
    check("pin_chk32",  {4'h0, model_rgb(32,  32, 1, 0)}, 16'h0000);
    check("pin_grad",   {4'h0, model_rgb(639, 479, 2, 0)}, 16'h09E0);
`ifdef PATTERN_SCROLL_EN
    check("pin_box_in",  {4'h0, model_rgb(2,  208, 3, 1)}, 16'h0FFF);
    check("pin_box_out", {4'h0, model_rgb(66, 208, 3, 1)}, 16'h000F);
`else
    check("pin_chk320", {4'h0, model_rgb(32,  0,  1, 0)}, 16'h0FFF);
    check("pin_box_in",  {4'h0, model_rgb(288, 208, 3, 0)}, 16'h0FFF);
    check("pin_box_out", {4'h0, model_rgb(352, 208, 3, 0)}, 16'h000F);
`endif

    // Bars on line 10.
    sel = 2'd0;
    pix(0, 0);
    for (int h = 0; h < 80; h++) pix(h, 10);
    pix(80, 10); pix(240, 10); pix(600, 10);

    // Blanking.
    pix(700, 10);
    idle(3);

    // Horizontal sync run length.
    hs_before = hs_low_total;
    for (int h = 640; h < 800; h++) pix(h, 10);
    idle(3);
    check("hsync_low_run", 16'(hs_low_total - hs_before), 16'd96);

    // Mid-frame pattern switch waits for the next frame.
    sel = 2'd0;
    pix(0, 0); pix(50, 50);
    sel = 2'd1;
    pix(0, 100); pix(90, 100); pix(32, 32); pix(240, 100);
    pix(0, 0); pix(32, 0); pix(32, 32); pix(100, 100);

    // Reset in the middle of a frame.
    pix(300, 200); pix(301, 200);
    do_reset(2);
    sel = 2'd1;
    pix(302, 200); pix(310, 200); pix(320, 200);

    // Random pixels under each pattern.
    for (int p = 0; p < 4; p++) begin
      sel = 2'(p);
      pix(0, 0);
      for (int k = 0; k < 40; k++) pix($urandom_range(0, 799), $urandom_range(0, 524));
    end
    idle(3);

    // Box placement, then 256 more frames back to the same frame_cnt.
    do_reset(2);
    sel = 2'd3;
    pix(0, 0);
    for (int r = 0; r < 2; r++) begin
      pix(2, 208); pix(65, 271); pix(66, 208); pix(2, 272); pix(1, 208);
      pix(288, 208); pix(351, 271); pix(352, 208); pix(288, 272); pix(287, 208);
      if (r == 0) begin
        for (int f = 0; f < 256; f++) begin
          pix(0, 0);
          pix(5, 5);
        end
      end
    end
    idle(4);

    check("frame_ticks", 16'(tick_total), 16'(fs_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-stage consumer of the 640x480 VGA timing generator. Same clk_pix domain.
- Takes hcount, vcount, hsync, vsync and de, and produces registered 4:4:4 RGB.
- Delays the syncs so they stay aligned with the colour data.
- Generates four selectable test patterns. A pattern change takes effect only at a frame boundary, so a frame never shows two patterns.

Parameters:
- COLOR_W, 4, bits per colour channel.
- CHECK_SHIFT, 5, checker square edge = 2^CHECK_SHIFT pixels (32).
- BOX_SIZE, 64, edge of the box in pattern 3, in pixels.
- BOX_Y, 208, top row of the box in pattern 3.

Ports:
- clk_pix  in  1  pixel clock, 25.175 MHz nominal.
- resetn  in  1  asynchronous, active-low reset.
- hcount  in  10  horizontal position from the timing generator, 0..799.
- vcount  in  10  vertical position from the timing generator, 0..524.
- hsync_in  in  1  timing-generator hsync, active-low.
- vsync_in  in  1  timing-generator vsync, active-low.
- de_in  in  1  active-video enable.
- pat_sel  in  2  requested pattern: 0 bars, 1 checker, 2 gradient, 3 box.
- red  out  COLOR_W  red channel.
- green  out  COLOR_W  green channel.
- blue  out  COLOR_W  blue channel.
- hsync_out  out  1  hsync_in delayed to align with RGB.
- vsync_out  out  1  vsync_in delayed to align with RGB.
- de_out  out  1  de_in delayed to align with RGB.
- frame_tick  out  1  one-cycle pulse coincident with output pixel (0,0).

Behaviour:
- Reset (asynchronous, resetn=0):
  - red/green/blue = 0, de_out = 0, frame_tick = 0.
  - hsync_out = 1 and vsync_out = 1 (inactive).
  - pat_active = 0, frame_cnt = 0.
  - All pipeline registers cleared to these same values.
  - Reset asserted mid-frame takes effect immediately. After release, output restarts from the next input sample.
- Fixed two-stage pipeline (latency 2 clk_pix):
  - S1 registers the timing inputs and computes the pattern colour.
  - S2 applies blanking and registers the outputs.
  - Input at cycle n appears on all outputs at cycle n+2.
- Frame start (fs) = (hcount==0 && vcount==0) at the input. On fs:
  - pat_active <= pat_sel.
  - frame_cnt (8-bit) increments, wrapping 255 to 0.
  - The fs flag travels down the pipeline and emerges as frame_tick.
- pat_sel is ignored at all other times. pat_active is the only pattern source for the whole frame.
- Pattern 0, colour bars:
  - bar = hcount/80 via a comparator chain, 0..7 across 0..639.
  - RGB bits per bar: 111, 110, 011, 010, 101, 100, 001, 000. Each set bit drives its channel to all-ones, each clear bit to 0.
- Pattern 1, checker: all channels = all-ones when hcount[CHECK_SHIFT] ^ vcount[CHECK_SHIFT] = 1, else 0.
- Pattern 2, gradient: red = hcount[9:6] (0..9 in active area), green = vcount[8:5], blue = 0.
- Pattern 3, box:
  - White (all-ones) box, BOX_SIZE square, top edge BOX_Y, left edge box_x.
  - Background: blue = all-ones, red = green = 0.
  - Box spans box_x <= hcount < box_x+BOX_SIZE and BOX_Y <= vcount < BOX_Y+BOX_SIZE. Compare at 11 bits so the right edge does not wrap.
- Blanking: when the delayed de = 0, RGB output = 0 regardless of pattern.
- Out-of-range counts (hcount>=640 or vcount>=480 with de_in=1) are not checked. Colour is computed as above, no other effect.

Optional Feature:
- Macro: PATTERN_SCROLL_EN.
- Defined:
  - box_x = {frame_cnt,1'b0} (0..510), so the box moves 2 px per frame and wraps.
  - The checker uses (hcount + frame_cnt) in place of hcount, scrolling left.
- Undefined:
  - box_x = 288 (box centred).
  - Checker is static.
  - frame_cnt is still maintained; frame_tick is unchanged.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525.
  - Pattern codes PAT_BARS/PAT_CHECK/PAT_GRAD/PAT_BOX.
  - The 8-entry bar colour table.
- One sub-module, vga_sync_delay:
  - Parameterised depth/width shift register with asynchronous active-low reset and per-bit reset values.
  - Carries hsync, vsync, de and fs through 2 stages.
- The timing generator instantiates the same vga_pkg constants.

Test Plan:
- Reset mid-frame: resetn=0 at (300,200) -> RGB=000, hsync_out=vsync_out=1, de_out=0 within the same cycle. After release, first valid output follows 2 cycles later.
- Bars: pat_sel=0 before fs, sample line vcount=10 -> hcount 0..79 gives FFF, 80 gives FF0, 240 gives 0F0, 600 gives 000. All at +2 cycles.
- Blanking: hcount=700, de_in=0, pattern 0 -> RGB=000 and de_out=0 at +2.
- Mid-frame switch: pat_sel 0->1 at vcount=100 -> bars continue to end of frame. Next frame gives (0,0)=000, (32,0)=FFF, (32,32)=000.
- Sync alignment: hsync_in low for hcount 656..751 -> hsync_out low for exactly 96 cycles, starting 2 cycles later. frame_tick pulses once per 420000 cycles.
- PATTERN_SCROLL_EN defined, pattern 3, frame_cnt=1 -> box white at (2,208) and (65,271), blue at (66,208) and (2,272). After 256 frames frame_cnt=1 again, with the box at the same location.
